// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg
//   Shared definitions for the pipeline sequencer. These are the inter-stage
//   slice indices, the sequencer state encoding, and the PC-select encoding.
//   Optional build macro RISCV_PIPE_PERF_EN is consumed by riscv_pipe_ctrl.
package riscv_pipe_pkg;

   localparam int NSTAGE_V1 = 4;
   localparam int IFID      = 0;
   localparam int IDEX      = 1;
   localparam int EXMEM     = 2;
   localparam int MEMWB     = 3;

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      PC_SEQ   = 2'd0,
      PC_REDIR = 2'd1,
      PC_TRAP  = 2'd2
   } pc_sel_e;

   // Slice controls as seen by the register slices: a flushed slice must also
   // be enabled so the sft_rst value actually loads.
   typedef struct packed {
      logic [NSTAGE_V1-1:0] en;
      logic [NSTAGE_V1-1:0] flush;
   } slice_ctl_t;

   function automatic slice_ctl_t mk_ctl(input logic [NSTAGE_V1-1:0] en,
                                         input logic [NSTAGE_V1-1:0] flush);
      slice_ctl_t c;
      c.en    = en | flush;
      c.flush = flush;
      return c;
   endfunction

endpackage

// File: rtl/riscv_hazard_det.sv
// riscv_hazard_det
//   Combinational load-use detector. Flags a stall when the instruction in EX
//   is a load whose destination (non-x0) is a source of the instruction in ID.
// Ports
//   i_id_rs1, i_id_rs2 : source registers of the ID instruction
//   i_ex_rd            : destination register of the EX instruction
//   i_ex_is_load       : EX instruction is a load
//   o_stall            : load-use hazard present this cycle
module riscv_hazard_det #(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] i_id_rs1,
   input  logic [REG_ADDR_W-1:0] i_id_rs2,
   input  logic [REG_ADDR_W-1:0] i_ex_rd,
   input  logic                  i_ex_is_load,
   output logic                  o_stall
);

   logic w_rd_nz;
   logic w_match;

   assign w_rd_nz = (i_ex_rd != '0);
   assign w_match = (i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2);
   assign o_stall = i_ex_is_load && w_rd_nz && w_match;

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// riscv_pipe_ctrl
//   Central sequencer for the 5-stage core. It drives en/sft_rst of the IF/ID,
//   ID/EX, EX/MEM and MEM/WB slices from trap, memory/EX busy, redirect and
//   load-use conditions. After a redirect or trap with a fetch in flight, it
//   drops the stale fetch response (DRAIN). A stall watchdog raises a sticky
//   hang flag.
//   Optional feature: define RISCV_PIPE_PERF_EN to add the perf counters.
// Ports
//   i_clk, i_rst         : clock, synchronous active-high reset
//   i_imem_rsp_valid     : fetch response valid this cycle
//   i_imem_outstanding   : a fetch response is still pending
//   i_dmem_busy          : MEM-stage access not complete
//   i_ex_busy            : multicycle EX unit not done
//   i_ex_redirect        : taken branch/jump resolved in EX
//   i_trap               : exception/interrupt taken at MEM
//   i_id_rs1/i_id_rs2    : ID source registers
//   i_ex_rd/i_ex_is_load : EX destination register, EX is a load
//   o_stage_en           : slice enables (combinational)
//   o_stage_flush        : slice soft resets (combinational)
//   o_pc_sel             : 0 sequential, 1 redirect, 2 trap vector
//   o_drop_fetch         : discard the current imem response
//   o_hang               : sticky watchdog flag (registered)
//   o_perf_stall_cnt     : cycles with IF/ID held (RISCV_PIPE_PERF_EN)
//   o_perf_flush_cnt     : trap/redirect events    (RISCV_PIPE_PERF_EN)
module riscv_pipe_ctrl
   import riscv_pipe_pkg::*;
#(
   parameter int NSTAGE        = 4,
   parameter int REG_ADDR_W    = 5,
   parameter int STALL_TIMEOUT = 1024,
   parameter int CNT_W         = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_imem_rsp_valid,
   input  logic                  i_imem_outstanding,
   input  logic                  i_dmem_busy,
   input  logic                  i_ex_busy,
   input  logic                  i_ex_redirect,
   input  logic                  i_trap,
   input  logic [REG_ADDR_W-1:0] i_id_rs1,
   input  logic [REG_ADDR_W-1:0] i_id_rs2,
   input  logic [REG_ADDR_W-1:0] i_ex_rd,
   input  logic                  i_ex_is_load,
   output logic [NSTAGE-1:0]     o_stage_en,
   output logic [NSTAGE-1:0]     o_stage_flush,
   output logic [1:0]            o_pc_sel,
   output logic                  o_drop_fetch,
   output logic                  o_hang
`ifdef RISCV_PIPE_PERF_EN
   ,
   output logic [CNT_W-1:0]      o_perf_stall_cnt,
   output logic [CNT_W-1:0]      o_perf_flush_cnt
`endif
);

   localparam int              WD_W   = $clog2(STALL_TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TIMEOUT);

   // The slice map is hard-wired to four slices; catch a bad override early.
   if (NSTAGE != NSTAGE_V1 || STALL_TIMEOUT < 2 || CNT_W < 1) begin : g_param_chk
      $error("riscv_pipe_ctrl: unsupported parameter set");
   end

   state_e          r_state;
   logic [WD_W-1:0] r_wd_cnt;
   logic            r_hang;

   state_e          w_state_nxt;
   logic [WD_W-1:0] w_wd_nxt;
   logic [3:0]      w_en;
   logic [3:0]      w_flush;
   pc_sel_e         w_pc_sel;
   logic            w_drop;
   logic            w_stall;   // dmem/ex busy row actually won priority
   logic            w_evt;     // trap or redirect row actually won priority
   logic            w_lu_stall;
   slice_ctl_t      w_ctl;

   riscv_hazard_det #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard (
      .i_id_rs1     (i_id_rs1),
      .i_id_rs2     (i_id_rs2),
      .i_ex_rd      (i_ex_rd),
      .i_ex_is_load (i_ex_is_load),
      .o_stall      (w_lu_stall)
   );

   always_comb begin
      w_en        = '1;
      w_flush     = '0;
      w_pc_sel    = PC_SEQ;
      w_drop      = 1'b0;
      w_stall     = 1'b0;
      w_evt       = 1'b0;
      w_state_nxt = r_state;

      if (i_rst || r_state == ST_HOLD) begin
         // Reset and the first cycle after it bubble every slice.
         w_flush     = '1;
         w_state_nxt = ST_RUN;
      end else begin
         if (i_trap) begin
            w_flush  = '1;
            w_pc_sel = PC_TRAP;
            w_evt    = 1'b1;
         end else if (i_dmem_busy) begin
            w_en[EXMEM:IFID] = '0;
            w_flush[MEMWB]   = 1'b1;
            w_stall          = 1'b1;
         end else if (i_ex_busy) begin
            w_en[IDEX:IFID]  = '0;
            w_flush[EXMEM]   = 1'b1;
            w_stall          = 1'b1;
         end else if (i_ex_redirect) begin
            w_flush[IDEX:IFID] = '1;
            w_pc_sel           = PC_REDIR;
            w_evt              = 1'b1;
         end else if (w_lu_stall) begin
            w_en[IFID]    = 1'b0;
            w_flush[IDEX] = 1'b1;
         end else if (!i_imem_rsp_valid) begin
            w_flush[IFID] = 1'b1;
         end

         if (r_state == ST_DRAIN) begin
            // IF/ID always takes a bubble here; whatever arrives is stale.
            w_flush[IFID] = 1'b1;
            w_drop        = 1'b1;
            if (w_evt)
               w_state_nxt = ST_DRAIN;
            else if (i_imem_rsp_valid)
               w_state_nxt = ST_RUN;
            else
               w_state_nxt = ST_DRAIN;
         end else begin
            w_state_nxt = (w_evt && i_imem_outstanding) ? ST_DRAIN : ST_RUN;
         end
      end
   end

   always_comb begin
      if (!w_stall)
         w_wd_nxt = '0;
      else if (r_wd_cnt == WD_MAX)
         w_wd_nxt = r_wd_cnt;
      else
         w_wd_nxt = r_wd_cnt + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_HOLD;
         r_wd_cnt <= '0;
         r_hang   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_wd_cnt <= w_wd_nxt;
         if (w_wd_nxt == WD_MAX)
            r_hang <= 1'b1;
      end
   end

   assign w_ctl         = mk_ctl(w_en, w_flush);
   assign o_stage_en    = w_ctl.en;
   assign o_stage_flush = w_ctl.flush;
   assign o_pc_sel      = w_pc_sel;
   assign o_drop_fetch  = w_drop;
   assign o_hang        = r_hang;

`ifdef RISCV_PIPE_PERF_EN
   logic [CNT_W-1:0] r_perf_stall;
   logic [CNT_W-1:0] r_perf_flush;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_perf_stall <= '0;
         r_perf_flush <= '0;
      end else begin
         if (!w_ctl.en[IFID])
            r_perf_stall <= r_perf_stall + 1'b1;
         if (w_evt)
            r_perf_flush <= r_perf_flush + 1'b1;
      end
   end

   assign o_perf_stall_cnt = r_perf_stall;
   assign o_perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// tb_riscv_pipe_ctrl
//   Directed vectors with hand-computed expectations. Each vector drives the
//   inputs just after a rising edge and pushes its expected outputs into a
//   queue; a monitor pops and compares on the falling edge of the same cycle.
//   Control word c = {rst, rsp_valid, outstanding, dmem_busy, ex_busy,
//                     redirect, trap, ex_is_load}.
module tb_riscv_pipe_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rsp = 1'b0, outst = 1'b0, dmem = 1'b0, exb = 1'b0;
   logic       redir = 1'b0, trap = 1'b0, load = 1'b0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic [3:0] en, fl;
   logic [1:0] pc;
   logic       drop, hang;
`ifdef RISCV_PIPE_PERF_EN
   logic [31:0] p_stall, p_flush;
`endif

   typedef struct {
      string      nm;
      logic [3:0] en;
      logic [3:0] fl;
      logic [1:0] pc;
      logic       drop;
      logic       hang;
      logic       chk_perf;
      int         p_stall;
      int         p_flush;
   } exp_t;

   exp_t sbq[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   riscv_pipe_ctrl #(
      .NSTAGE        (4),
      .REG_ADDR_W    (5),
      .STALL_TIMEOUT (8),
      .CNT_W         (32)
   ) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_imem_rsp_valid   (rsp),
      .i_imem_outstanding (outst),
      .i_dmem_busy        (dmem),
      .i_ex_busy          (exb),
      .i_ex_redirect      (redir),
      .i_trap             (trap),
      .i_id_rs1           (rs1),
      .i_id_rs2           (rs2),
      .i_ex_rd            (rd),
      .i_ex_is_load       (load),
      .o_stage_en         (en),
      .o_stage_flush      (fl),
      .o_pc_sel           (pc),
      .o_drop_fetch       (drop),
      .o_hang             (hang)
`ifdef RISCV_PIPE_PERF_EN
      ,
      .o_perf_stall_cnt   (p_stall),
      .o_perf_flush_cnt   (p_flush)
`endif
   );

   task automatic vec(input string nm, input logic [7:0] c,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                      input logic [3:0] e_en, input logic [3:0] e_fl, input logic [1:0] e_pc,
                      input logic e_drop, input logic e_hang,
                      input logic cp, input int ps, input int pf);
      exp_t e;
      @(posedge clk);
      #1;
      {rst, rsp, outst, dmem, exb, redir, trap, load} = c;
      rs1 = r1; rs2 = r2; rd = d;
      e.nm = nm; e.en = e_en; e.fl = e_fl; e.pc = e_pc;
      e.drop = e_drop; e.hang = e_hang;
      e.chk_perf = cp; e.p_stall = ps; e.p_flush = pf;
      sbq.push_back(e);
   endtask

   // Monitor: outputs are combinational, so each vector is checked mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         n_chk++;
         if (en === e.en && fl === e.fl && pc === e.pc && drop === e.drop && hang === e.hang)
            n_pass++;
         else
            $display("FAIL %s: got en=%b fl=%b pc=%0d drop=%b hang=%b, want en=%b fl=%b pc=%0d drop=%b hang=%b",
                     e.nm, en, fl, pc, drop, hang, e.en, e.fl, e.pc, e.drop, e.hang);
`ifdef RISCV_PIPE_PERF_EN
         if (e.chk_perf) begin
            n_chk++;
            if (p_stall == e.p_stall && p_flush == e.p_flush)
               n_pass++;
            else
               $display("FAIL %s_perf: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
                        e.nm, p_stall, p_flush, e.p_stall, e.p_flush);
         end
`endif
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, %0d checks pending", sbq.size());
      $fatal(1, "timeout");
   end

   initial begin
      // 1: reset, HOLD, then idle RUN without a fetch response
      for (int i = 0; i < 3; i++)
         vec("rst", 8'b1000_0000, 0, 0, 0, 4'b1111, 4'b1111, 2'd0, 0, 0, 0, 0, 0);
      vec("hold",         8'b0000_0000, 0, 0, 0, 4'b1111, 4'b1111, 2'd0, 0, 0, 0, 0, 0);
      vec("run_norsp",    8'b0000_0000, 0, 0, 0, 4'b1111, 4'b0001, 2'd0, 0, 0, 0, 0, 0);
      // 2: load-use on rs2, x0 destination, load-use on rs1
      vec("lu_rs2",       8'b0100_0001, 0, 5, 5, 4'b1110, 4'b0010, 2'd0, 0, 0, 0, 0, 0);
      vec("lu_rd0",       8'b0100_0001, 0, 0, 0, 4'b1111, 4'b0000, 2'd0, 0, 0, 0, 0, 0);
      vec("lu_rs1",       8'b0100_0001, 7, 0, 7, 4'b1110, 4'b0010, 2'd0, 0, 0, 0, 0, 0);
      // 3: redirect with fetch in flight -> DRAIN until the stale response
      vec("redir",        8'b0110_0100, 0, 0, 0, 4'b1111, 4'b0011, 2'd1, 0, 0, 0, 0, 0);
      vec("drain_wait",   8'b0010_0000, 0, 0, 0, 4'b1111, 4'b0001, 2'd0, 1, 0, 0, 0, 0);
      vec("drain_drop",   8'b0100_0000, 0, 0, 0, 4'b1111, 4'b0001, 2'd0, 1, 0, 0, 0, 0);
      vec("drain_exit",   8'b0100_0000, 0, 0, 0, 4'b1111, 4'b0000, 2'd0, 0, 0, 0, 0, 0);
      // trap while draining keeps DRAIN even with a response present
      vec("redir2",       8'b0110_0100, 0, 0, 0, 4'b1111, 4'b0011, 2'd1, 0, 0, 0, 0, 0);
      vec("drain_trap",   8'b0100_0010, 0, 0, 0, 4'b1111, 4'b1111, 2'd2, 1, 0, 0, 0, 0);
      vec("drain_drop2",  8'b0100_0000, 0, 0, 0, 4'b1111, 4'b0001, 2'd0, 1, 0, 0, 0, 0);
      // reset in the middle of DRAIN discards it
      vec("redir3",       8'b0110_0100, 0, 0, 0, 4'b1111, 4'b0011, 2'd1, 0, 0, 0, 0, 0);
      vec("rst_drain",    8'b1000_0000, 0, 0, 0, 4'b1111, 4'b1111, 2'd0, 0, 0, 0, 0, 0);
      vec("hold2",        8'b0100_0000, 0, 0, 0, 4'b1111, 4'b1111, 2'd0, 0, 0, 0, 0, 0);
      vec("run_clean",    8'b0100_0000, 0, 0, 0, 4'b1111, 4'b0000, 2'd0, 0, 0, 0, 0, 0);
      // 4: trap beats dmem_busy
      vec("trap_dmem",    8'b0101_0010, 0, 0, 0, 4'b1111, 4'b1111, 2'd2, 0, 0, 0, 0, 0);
      vec("post_trap",    8'b0100_0000, 0, 0, 0, 4'b1111, 4'b0000, 2'd0, 0, 0, 0, 0, 0);
      // 5: watchdog with STALL_TIMEOUT=8
      for (int i = 0; i < 8; i++)
         vec("dmem_stall",  8'b0101_0000, 0, 0, 0, 4'b1000, 4'b1000, 2'd0, 0, 0, 0, 0, 0);
      vec("hang_set",     8'b0100_0000, 0, 0, 0, 4'b1111, 4'b0000, 2'd0, 0, 1, 0, 0, 0);
      vec("hang_sticky",  8'b0100_0000, 0, 0, 0, 4'b1111, 4'b0000, 2'd0, 0, 1, 0, 0, 0);
      vec("hang_in_rst",  8'b1000_0000, 0, 0, 0, 4'b1111, 4'b1111, 2'd0, 0, 1, 0, 0, 0);
      vec("hang_clr",     8'b0100_0000, 0, 0, 0, 4'b1111, 4'b1111, 2'd0, 0, 0, 0, 0, 0);
      // 6: ex_busy outranks load-use, then load-use stall on the 4th cycle
      for (int i = 0; i < 3; i++)
         vec("exb_lu",      8'b0100_1001, 5, 0, 5, 4'b1100, 4'b0100, 2'd0, 0, 0, 0, 0, 0);
      vec("lu_after_exb", 8'b0100_0001, 5, 0, 5, 4'b1110, 4'b0010, 2'd0, 0, 0, 0, 0, 0);
      vec("resume",       8'b0100_0000, 0, 0, 0, 4'b1111, 4'b0000, 2'd0, 0, 0, 1, 4, 0);

      for (int i = 0; i < 20 && sbq.size() > 0; i++)
         @(posedge clk);
      @(posedge clk);
      if (sbq.size() > 0) begin
         n_chk++;
         $display("FAIL drain_queue: got %0d pending, want 0", sbq.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
